// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous boot ROM between N read masters.
// One access per cycle; responses return exactly one cycle after the grant.
module boot_rom_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ROM_ADDR_WIDTH = 13
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_MASTERS-1:0]          req_i,
  input  logic [N_MASTERS-1:0][31:0]    add_i,
  input  logic [N_MASTERS-1:0]          wen_i,
  output logic [N_MASTERS-1:0]          gnt_o,
  output logic [N_MASTERS-1:0]          r_valid_o,
  output logic [31:0]                   r_rdata_o,
  output logic                          r_opc_o,
  output logic                          rom_csn_o,
  output logic [ROM_ADDR_WIDTH-3:0]     rom_add_o,
  input  logic [31:0]                   rom_rdata_i
);

  localparam int              PTR_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_MASTERS - 1);

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [2*N_MASTERS-1:0] req_rot_s;
  logic [PTR_W:0]         cand_sum_s;
  logic [PTR_W:0]         cand_s;
  logic                   gnt_any_s;
  logic [PTR_W-1:0]       gnt_idx_s;
  logic [31:0]            sel_add_s;
  logic                   sel_wen_s;
  logic                   rd_ok_s;
  logic [N_MASTERS-1:0]   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;

  // Rotate requests so bit 0 is the master at rr_ptr; scan downwards so the lowest rotated hit wins.
  always_comb begin
    req_rot_s  = {req_i, req_i} >> rr_ptr_q;
    gnt_idx_s  = '0;
    cand_sum_s = '0;
    cand_s     = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      cand_sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      cand_s     = (cand_sum_s >= (PTR_W+1)'(N_MASTERS)) ?
                   (cand_sum_s - (PTR_W+1)'(N_MASTERS)) : cand_sum_s;
      gnt_idx_s  = req_rot_s[i] ? cand_s[PTR_W-1:0] : gnt_idx_s;
    end
    gnt_any_s = rst_ni & (|req_i);
    for (int i = 0; i < N_MASTERS; i++) begin
      gnt_o[i] = gnt_any_s && (gnt_idx_s == PTR_W'(i));
    end
  end

  // Classify the granted access and drive the ROM port.
  always_comb begin
    sel_add_s = add_i[gnt_idx_s];
    sel_wen_s = wen_i[gnt_idx_s];
    rd_ok_s   = sel_wen_s && (sel_add_s[31:ROM_ADDR_WIDTH] == '0);
    rom_csn_o = ~(gnt_any_s & rd_ok_s);
    rom_add_o = (gnt_any_s && rd_ok_s) ? sel_add_s[ROM_ADDR_WIDTH-1:2] : '0;
  end

  // Next-state for pointer and the one-cycle response pipeline.
  always_comb begin
    if (gnt_any_s) begin
      rr_ptr_d = (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    rsp_valid_d = gnt_o;
    rsp_err_d   = gnt_any_s & ~rd_ok_s;
  end

  // State registers; async reset discards any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // ROM data is only forwarded on a successful read response; otherwise zero.
  always_comb begin
    r_valid_o = rsp_valid_q;
    r_opc_o   = (|rsp_valid_q) & rsp_err_q;
    r_rdata_o = ((|rsp_valid_q) && !rsp_err_q) ? rom_rdata_i : 32'h0000_0000;
  end

endmodule
